regheap_wb_arbiter: RTL and testbench
=====================================

// Module: regheap_wb_arbiter
// PURPOSE
//  Shares the single write port of regHeap between two write-back requesters:
//  A = ALU result path, B = load/multi-cycle path.
//  Grants one write per cycle, round-robin on conflict, and registers rd/W/s_write into regHeap.
//  Keeps a 32-bit pending-write scoreboard (busy) for the hazard/stall logic.
// PARAMETERS
//  ADDR_W  5   register index width
//  DATA_W  32  register data width
//  NREG    32  number of registers; busy width
// PORTS
//  clk         in   1       clock, all state updates on rising edge
//  clr         in   1       reset, asynchronous, active-low
//  a_valid     in   1       requester A has a write pending
//  a_ready     out  1       A accepted this cycle (combinational)
//  a_rd        in   ADDR_W  A destination register
//  a_data      in   DATA_W  A write data
//  b_valid     in   1       requester B has a write pending
//  b_ready     out  1       B accepted this cycle (combinational)
//  b_rd        in   ADDR_W  B destination register
//  b_data      in   DATA_W  B write data
//  iss_valid   in   1       an instruction issues with a destination register
//  iss_rd      in   ADDR_W  destination of the issuing instruction
//  rd          out  ADDR_W  to regHeap.rd (registered)
//  W           out  DATA_W  to regHeap.W (registered)
//  s_write     out  1       to regHeap.s_write (registered)
//  busy        out  NREG    busy[i]=1: write to reg i outstanding
// BEHAVIOUR
//  Reset (clr=0, async): rd=0, W=0, s_write=0, busy=0, rr pointer = A. An accepted but
//    uncommitted write is discarded. a_ready/b_ready are forced 0 while clr=0.
//  Handshake: transfer when valid&&ready at a rising edge. Requester holds valid/rd/data
//    stable until ready. Ready never depends on anything except both valids and rr pointer.
//  Arbitration: only one valid -> that one is granted. Both valid -> grant the side not granted
//    last; rr pointer updates only on a conflict grant. First conflict after reset -> A.
//  Latency: a transfer at edge N sets rd/W/s_write=1 for cycle N..N+1. regHeap commits at
//    edge N+1. No accepting cycle -> s_write=0 next cycle; rd/W hold their last value.
//  Throughput: one write per cycle, no bubbles under back-to-back requests.
//  rd==0: handshake completes normally, s_write stays 0, busy unaffected.
//  Scoreboard:
//    - iss_valid at edge sets busy[iss_rd].
//    - An edge with s_write=1 clears busy[rd] (the commit edge).
//    - Same edge, same index, set and clear -> set wins (newer producer).
//    - busy[0] is constant 0.
//    - Set/clear at different indices both apply.
//  Overlap: two outstanding writers to the same rd are allowed. busy clears at the first
//    commit. Ordering between them is the issuer's responsibility.
//  No internal data storage beyond the output register; no FIFOs.
// STRUCTURE
//  Package regheap_pkg: ADDR_W, DATA_W, NREG constants; typedefs reg_addr_t, reg_data_t;
//    REG_ZERO constant. Shared with regHeap and the hazard unit.
//  Sub-module rr_arb2: 2-way round-robin arbiter.
//    - Inputs: req[1:0], clk, clr.
//    - Outputs: gnt[1:0] one-hot or zero.
//    - Owns the pointer.
//  Output register and scoreboard inline in this module.
// TESTING
//  1 Reset: drive a_valid=1, a_rd=4, then clr=0 mid-cycle -> s_write=0, busy=0 immediately,
//    a_ready=0 while clr=0.
//  2 Single A: a_valid=1, a_rd=4, a_data=32'habcd -> a_ready=1 same cycle; next cycle
//    s_write=1, rd=4, W=32'habcd. After commit, regHeap rs=4 gives o_A=32'habcd.
//  3 Conflict: A (rd=1, 32'h11) and B (rd=2, 32'h22) valid 4 cycles from reset -> grants
//    A,B,A,B. s_write sequence writes r1,r2,r1,r2; no idle cycle.
//  4 Zero reg: a_valid=1, a_rd=0, a_data=32'hffff -> a_ready=1; s_write stays 0;
//    regHeap r0 unchanged.
//  5 Scoreboard: iss_valid rd=7 -> busy[7]=1 next cycle; B writes r7 -> busy[7]=0 after
//    commit edge. iss rd=7 on the commit edge -> busy[7] stays 1.
//  6 iss_valid with iss_rd=0 -> busy remains 32'h0.

Source files
------------

// File: rtl/regheap_pkg.sv
// rtl/regheap_pkg.sv - shared register-heap widths, types and constants
package regheap_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 32;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_addr_t REG_ZERO = '0;

    typedef enum logic {
        PTR_A = 1'b0,
        PTR_B = 1'b1
    } rr_ptr_e;

endpackage

// File: rtl/regheap_wb_arbiter_rr_arb2.sv
// rtl/regheap_wb_arbiter_rr_arb2.sv - two-way round-robin arbiter owning its pointer
module rr_arb2
    import regheap_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    rr_ptr_e ptr_q;
    rr_ptr_e ptr_d;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ptr_q <= PTR_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // The pointer only moves when both sides compete; lone grants leave it alone.
    always_comb begin
        ptr_d = ptr_q;
        if (req == 2'b11) begin
            ptr_d = (ptr_q == PTR_A) ? PTR_B : PTR_A;
        end
    end

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (ptr_q == PTR_A) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        if (!clr) begin
            gnt = 2'b00;
        end
    end

endmodule

// File: rtl/regheap_wb_arbiter.sv
// rtl/regheap_wb_arbiter.sv - shares the regHeap write port between two requesters, tracks pending writes
module regheap_wb_arbiter
    import regheap_pkg::*;
#(
    parameter int ADDR_W = regheap_pkg::ADDR_W,
    parameter int DATA_W = regheap_pkg::DATA_W,
    parameter int NREG   = regheap_pkg::NREG
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] W,
    output logic              s_write,
    output logic [NREG-1:0]   busy
);

    logic [1:0]        gnt;
    logic              a_take;
    logic              b_take;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;

    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] w_q, w_d;
    logic              s_write_q, s_write_d;
    logic [NREG-1:0]   busy_q, busy_d;

    rr_arb2 u_rr_arb2 (
        .clk (clk),
        .clr (clr),
        .req ({b_valid, a_valid}),
        .gnt (gnt)
    );

    assign a_ready = gnt[0];
    assign b_ready = gnt[1];
    assign a_take  = a_valid && a_ready;
    assign b_take  = b_valid && b_ready;

    always_comb begin
        sel_rd   = a_rd;
        sel_data = a_data;
        if (b_take) begin
            sel_rd   = b_rd;
            sel_data = b_data;
        end
    end

    // A write to r0 still completes its handshake but never reaches the heap.
    always_comb begin
        rd_d      = rd_q;
        w_d       = w_q;
        s_write_d = 1'b0;
        if (a_take || b_take) begin
            rd_d      = sel_rd;
            w_d       = sel_data;
            s_write_d = (sel_rd != ADDR_W'(REG_ZERO));
        end
    end

    // Clear first so a same-edge issue to the committing register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (s_write_q) begin
            busy_d[rd_q] = 1'b0;
        end
        if (iss_valid) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rd_q      <= '0;
            w_q       <= '0;
            s_write_q <= 1'b0;
            busy_q    <= '0;
        end else begin
            rd_q      <= rd_d;
            w_q       <= w_d;
            s_write_q <= s_write_d;
            busy_q    <= busy_d;
        end
    end

    assign rd      = rd_q;
    assign W       = w_q;
    assign s_write = s_write_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_regheap_wb_arbiter.sv
// tb/tb_regheap_wb_arbiter.sv - directed self-checking bench for regheap_wb_arbiter
module tb_regheap_wb_arbiter;

    logic        clk;
    logic        clr;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  rd;
    logic [31:0] W;
    logic        s_write;
    logic [31:0] busy;

    logic [31:0] rf [32];
    int          n_checks;
    int          n_fail;

    regheap_wb_arbiter dut (
        .clk       (clk),
        .clr       (clr),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_rd      (a_rd),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_rd      (b_rd),
        .b_data    (b_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rd        (rd),
        .W         (W),
        .s_write   (s_write),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for regHeap: commits on the edge that sees s_write high.
    always @(posedge clk) begin
        if (s_write) begin
            rf[rd] <= W;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        clr       = 1'b0;
        a_valid   = 1'b1;
        a_rd      = 5'd4;
        a_data    = 32'h0;
        b_valid   = 1'b0;
        b_rd      = 5'd0;
        b_data    = 32'h0;
        iss_valid = 1'b0;
        iss_rd    = 5'd0;

        #1;
        check("rst_a_ready", a_ready, 0);
        check("rst_s_write", s_write, 0);
        check("rst_busy", busy, 0);
        check("rst_rd", rd, 0);
        check("rst_w", W, 0);
        repeat (2) @(posedge clk);
        #1;
        clr     = 1'b1;
        a_valid = 1'b0;

        iss_valid = 1'b1;
        iss_rd    = 5'd0;
        tick();
        iss_valid = 1'b0;
        check("iss_r0_busy", busy, 32'h0);

        a_valid = 1'b1;
        a_rd    = 5'd4;
        a_data  = 32'habcd;
        #1;
        check("single_a_ready", a_ready, 1);
        check("single_b_ready", b_ready, 0);
        tick();
        a_valid = 1'b0;
        check("single_s_write", s_write, 1);
        check("single_rd", rd, 4);
        check("single_w", W, 32'habcd);
        tick();
        check("single_idle_s_write", s_write, 0);
        check("single_hold_rd", rd, 4);
        check("single_hold_w", W, 32'habcd);
        check("single_rf4", rf[4], 32'habcd);

        iss_valid = 1'b1;
        iss_rd    = 5'd9;
        a_valid   = 1'b1;
        a_rd      = 5'd4;
        a_data    = 32'h4444;
        tick();
        iss_valid = 1'b0;
        check("pre_rst_s_write", s_write, 1);
        check("pre_rst_busy", busy, 32'h200);
        #2;
        clr = 1'b0;
        #1;
        check("async_s_write", s_write, 0);
        check("async_busy", busy, 0);
        check("async_rd", rd, 0);
        check("async_a_ready", a_ready, 0);
        #1;
        clr     = 1'b1;
        a_valid = 1'b0;
        tick();
        check("discard_rf4", rf[4], 32'habcd);

        a_valid = 1'b1;
        a_rd    = 5'd1;
        a_data  = 32'h11;
        b_valid = 1'b1;
        b_rd    = 5'd2;
        b_data  = 32'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("conf%0d_a_ready", k), a_ready, (k % 2 == 0));
            check($sformatf("conf%0d_b_ready", k), b_ready, (k % 2 == 1));
            tick();
            if (k == 3) begin
                a_valid = 1'b0;
                b_valid = 1'b0;
            end
            check($sformatf("conf%0d_s_write", k), s_write, 1);
            check($sformatf("conf%0d_rd", k), rd, (k % 2 == 0) ? 1 : 2);
            check($sformatf("conf%0d_w", k), W, (k % 2 == 0) ? 32'h11 : 32'h22);
        end
        tick();
        check("conf_idle_s_write", s_write, 0);
        check("conf_rf1", rf[1], 32'h11);
        check("conf_rf2", rf[2], 32'h22);

        b_valid = 1'b1;
        b_rd    = 5'd2;
        b_data  = 32'h23;
        #1;
        check("lone_b_ready", b_ready, 1);
        tick();
        b_valid = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        #1;
        check("ptr_hold_a_ready", a_ready, 1);
        check("ptr_hold_b_ready", b_ready, 0);
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();

        a_valid = 1'b1;
        a_rd    = 5'd0;
        a_data  = 32'hffff;
        #1;
        check("zero_a_ready", a_ready, 1);
        tick();
        a_valid = 1'b0;
        check("zero_s_write", s_write, 0);
        tick();
        check("zero_rf0", rf[0], 32'h0);
        check("zero_busy", busy, 32'h0);

        iss_valid = 1'b1;
        iss_rd    = 5'd7;
        tick();
        iss_valid = 1'b0;
        check("sb_set7", busy, 32'h80);
        b_valid = 1'b1;
        b_rd    = 5'd7;
        b_data  = 32'h77;
        #1;
        check("sb_b_ready", b_ready, 1);
        tick();
        b_valid = 1'b0;
        check("sb_s_write", s_write, 1);
        check("sb_pre_commit", busy, 32'h80);
        iss_valid = 1'b1;
        iss_rd    = 5'd5;
        tick();
        iss_valid = 1'b0;
        check("sb_commit_other_set", busy, 32'h20);
        check("sb_rf7", rf[7], 32'h77);

        iss_valid = 1'b1;
        iss_rd    = 5'd7;
        tick();
        iss_valid = 1'b0;
        check("sb_reset7", busy, 32'ha0);
        b_valid = 1'b1;
        b_rd    = 5'd7;
        b_data  = 32'h78;
        tick();
        b_valid = 1'b0;
        iss_valid = 1'b1;
        iss_rd    = 5'd7;
        tick();
        iss_valid = 1'b0;
        check("sb_set_wins", busy, 32'ha0);
        tick();
        check("sb_set_wins_hold", busy, 32'ha0);
        check("sb_rf7_second", rf[7], 32'h78);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
